// File: rtl/slow_tick_counter_if.sv
// Command/status bundle between the reaction-time controller and slow_tick_counter.
interface slow_tick_counter_if;
  logic        slow_in;
  logic        start;
  logic        stop;
  logic        clear;
  logic        tick;
  logic [15:0] bcd;
  logic        running;
  logic        overflow;

  modport master (
    output slow_in, start, stop, clear,
    input  tick, bcd, running, overflow
  );

  modport slave (
    input  slow_in, start, stop, clear,
    output tick, bcd, running, overflow
  );
endinterface

// File: rtl/slow_tick_counter.sv
// Synchronises the slow divider toggle into clk, turns each qualifying transition into a
// one-cycle tick and accumulates ticks in a saturating 4-digit BCD counter.
module slow_tick_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          BOTH_EDGES  = 1'b1
) (
  input logic             clk,
  input logic             reset,
  slow_tick_counter_if.slave bus
);

  localparam int unsigned ArmCycles = SYNC_STAGES + 1;
  localparam int unsigned ArmW      = $clog2(ArmCycles + 1);

  typedef enum logic [1:0] {StIdle, StRunning, StStopped, StOverflow} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [ArmW-1:0]        arm_q;
  logic                   tick_q;
  logic                   s_last;
  logic                   edge_det;
  logic                   armed;

  state_e      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bcd_inc;
  logic        carry;
  logic        at_max;

  assign s_last   = sync_q[SYNC_STAGES-1];
  assign edge_det = BOTH_EDGES ? (s_last ^ hist_q) : (s_last & ~hist_q);
  // Held off until the chain has flushed whatever level slow_in had at reset.
  assign armed    = (arm_q == ArmW'(ArmCycles));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      arm_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.slow_in};
      hist_q <= s_last;
      if (!armed) begin
        arm_q <= arm_q + ArmW'(1);
      end
      tick_q <= edge_det & armed;
    end
  end

  // Per-digit increment with decimal carry; digits never leave 0..9.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  assign at_max = (bcd_q == 16'h9999);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    if (bus.clear) begin
      state_d = StIdle;
      bcd_d   = '0;
    end else if (bus.stop) begin
      // stop masks start; a coincident tick is still counted (frozen at 9999 if full).
      if (state_q == StRunning) begin
        state_d = StStopped;
        if (tick_q && !at_max) begin
          bcd_d = bcd_inc;
        end
      end
    end else if (bus.start && (state_q != StRunning)) begin
      state_d = StRunning;
      bcd_d   = '0;
    end else if ((state_q == StRunning) && tick_q) begin
      if (at_max) begin
        state_d = StOverflow;
      end else begin
        bcd_d = bcd_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.bcd      = bcd_q;
  assign bus.running  = (state_q == StRunning);
  assign bus.overflow = (state_q == StOverflow);

endmodule
